sha256_block_loader: RTL and testbench

- Writer-side front end for the SHA-256 message schedule.
- Accepts a big-endian 32-bit message word stream, applies SHA-256 padding (0x80 byte, zero fill, 64-bit big-endian bit length), and buffers each 512-bit block.
- Replays each block to the schedule using that interface's timing: 16 write cycles, then 48 expansion cycles, then an idle gap that returns the schedule's internal counter to zero.
- Sits between the host/message FIFO and the message schedule core; its data/write_enable/inner_busy outputs drive the same-named schedule inputs.

---
 rtl/sha256_block_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_sha256_block_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_loader.sv
// SHA-256 block loader: pads a big-endian 32-bit word stream into 512-bit blocks
// and replays each block to the message schedule (16 writes, 48 expand, idle gap).
//
// state  | meaning
// IDLE   | waiting for the first word of a message
// FILL   | accepting message words into the block buffer
// PAD    | writing the 0x80 word, zero fill and bit length, one word per cycle
// EMIT   | 16 write cycles, buffer words 0..15 to the schedule
// EXPAND | 48 expansion cycles, schedule running without writes
// GAP    | schedule idle so its internal round counter returns to zero
module sha256_block_loader #(
    parameter int GAP_CYCLES = 1,
    parameter int LEN_W      = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    input  logic        msg_last,
    input  logic [1:0]  msg_bytes,
    output logic        msg_ready,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        inner_busy,
    output logic        block_first,
    output logic        block_last,
    output logic        msg_done,
    output logic        busy
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, FILL, PAD, EMIT, EXPAND, GAP} state_t;

    state_t           state;
    logic [31:0]      blk_buf [16];
    logic [4:0]       idx;
    logic [LEN_W-1:0] len;
    logic [5:0]       run_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             pad_pending;
    logic             len_fit;
    logic             need_extra;
    logic             more;
    logic             first_blk;

    logic             accept;
    logic [4:0]       wr_idx;
    logic [31:0]      in_word;
    logic [5:0]       add_bits;
    logic [LEN_W-1:0] len_next;

    // Last word: keep the valid bytes, place 0x80 right after them, zero the rest.
    always_comb begin
        accept   = msg_valid & msg_ready;
        wr_idx   = (state == IDLE) ? 5'd0 : idx;
        in_word  = msg_data;
        add_bits = 6'd32;
        if (msg_last) begin
            case (msg_bytes)
                2'd1:    in_word = {msg_data[31:24], 8'h80, 16'h0000};
                2'd2:    in_word = {msg_data[31:16], 8'h80, 8'h00};
                2'd3:    in_word = {msg_data[31:8], 8'h80};
                default: in_word = msg_data;
            endcase
            add_bits = (msg_bytes == 2'd0) ? 6'd32 : {1'b0, msg_bytes, 3'b000};
        end
        len_next = ((state == IDLE) ? {LEN_W{1'b0}} : len) + LEN_W'(add_bits);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            for (int i = 0; i < 16; i++) blk_buf[i] <= '0;
            idx          <= '0;
            len          <= '0;
            run_cnt      <= '0;
            gap_cnt      <= '0;
            pad_pending  <= 1'b0;
            len_fit      <= 1'b0;
            need_extra   <= 1'b0;
            more         <= 1'b0;
            first_blk    <= 1'b0;
            msg_ready    <= 1'b0;
            data         <= '0;
            write_enable <= 1'b0;
            inner_busy   <= 1'b0;
            block_first  <= 1'b0;
            block_last   <= 1'b0;
            msg_done     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            block_first  <= 1'b0;
            msg_done     <= 1'b0;
            data         <= '0;
            case (state)
                IDLE, FILL: begin
                    msg_ready <= 1'b1;
                    if (accept) begin
                        blk_buf[wr_idx[3:0]] <= in_word;
                        len   <= len_next;
                        idx   <= wr_idx + 5'd1;
                        busy  <= 1'b1;
                        state <= FILL;
                        if (state == IDLE) begin
                            first_blk   <= 1'b1;
                            len_fit     <= 1'b0;
                            need_extra  <= 1'b0;
                            more        <= 1'b0;
                            pad_pending <= 1'b0;
                        end
                        if (msg_last) begin
                            state     <= PAD;
                            msg_ready <= 1'b0;
                            if (msg_bytes == 2'd0) begin
                                pad_pending <= 1'b1;
                            end else begin
                                len_fit <= (wr_idx <= 5'd13);
                            end
                        end else if (wr_idx == 5'd15) begin
                            state        <= EMIT;
                            more         <= 1'b1;
                            msg_ready    <= 1'b0;
                            inner_busy   <= 1'b1;
                            write_enable <= 1'b1;
                            data         <= blk_buf[0];
                            idx          <= 5'd1;
                            run_cnt      <= 6'd15;
                            block_first  <= first_blk;
                            first_blk    <= 1'b0;
                            block_last   <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    msg_ready <= 1'b0;
                    // idx==16 only when the last word filled slot 15: nothing fits, so an extra block follows.
                    if (idx == 5'd16) begin
                        state        <= EMIT;
                        need_extra   <= 1'b1;
                        inner_busy   <= 1'b1;
                        write_enable <= 1'b1;
                        data         <= blk_buf[0];
                        idx          <= 5'd1;
                        run_cnt      <= 6'd15;
                        block_first  <= first_blk;
                        first_blk    <= 1'b0;
                        block_last   <= 1'b0;
                    end else begin
                        idx <= idx + 5'd1;
                        if (pad_pending) begin
                            blk_buf[idx[3:0]] <= 32'h8000_0000;
                            pad_pending       <= 1'b0;
                            if (idx <= 5'd13) len_fit <= 1'b1;
                        end else if (len_fit && idx == 5'd14) begin
                            blk_buf[14] <= len[LEN_W-1 -: 32];
                        end else if (len_fit && idx == 5'd15) begin
                            blk_buf[15] <= len[31:0];
                        end else begin
                            blk_buf[idx[3:0]] <= 32'h0000_0000;
                        end
                        if (idx == 5'd15) begin
                            state        <= EMIT;
                            need_extra   <= ~len_fit;
                            inner_busy   <= 1'b1;
                            write_enable <= 1'b1;
                            data         <= blk_buf[0];
                            idx          <= 5'd1;
                            run_cnt      <= 6'd15;
                            block_first  <= first_blk;
                            first_blk    <= 1'b0;
                            block_last   <= len_fit;
                        end
                    end
                end
                EMIT: begin
                    inner_busy <= 1'b1;
                    if (run_cnt == 6'd0) begin
                        state   <= EXPAND;
                        run_cnt <= 6'd47;
                    end else begin
                        write_enable <= 1'b1;
                        data         <= blk_buf[idx[3:0]];
                        idx          <= idx + 5'd1;
                        run_cnt      <= run_cnt - 6'd1;
                    end
                end
                EXPAND: begin
                    if (run_cnt == 6'd0) begin
                        state      <= GAP;
                        inner_busy <= 1'b0;
                        block_last <= 1'b0;
                        gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        run_cnt <= run_cnt - 6'd1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (need_extra) begin
                        // Extra block always carries the length; any pending 0x80 lands at slot 0.
                        state      <= PAD;
                        idx        <= 5'd0;
                        need_extra <= 1'b0;
                        len_fit    <= 1'b1;
                    end else if (more) begin
                        state     <= FILL;
                        idx       <= 5'd0;
                        more      <= 1'b0;
                        msg_ready <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        msg_done  <= 1'b1;
                        msg_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_block_loader.sv
// Bench for sha256_block_loader: byte-level SHA-256 padding model, per-cycle
// compare of the schedule-side outputs, randomized message stream with stalls.
module tb_sha256_block_loader;
    localparam int GAP_CYCLES = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        msg_valid;
    logic [31:0] msg_data;
    logic        msg_last;
    logic [1:0]  msg_bytes;
    logic        msg_ready;
    logic [31:0] data;
    logic        write_enable;
    logic        inner_busy;
    logic        block_first;
    logic        block_last;
    logic        msg_done;
    logic        busy;

    sha256_block_loader #(.GAP_CYCLES(GAP_CYCLES), .LEN_W(64)) dut (
        .clk(clk), .reset(reset), .msg_valid(msg_valid), .msg_data(msg_data),
        .msg_last(msg_last), .msg_bytes(msg_bytes), .msg_ready(msg_ready),
        .data(data), .write_enable(write_enable), .inner_busy(inner_busy),
        .block_first(block_first), .block_last(block_last), .msg_done(msg_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0] msg_words [$];
    bit [31:0] exp_w [$];
    bit        exp_first [$];
    bit        exp_last [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference padding: message bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
    task automatic build_expected(input int n, input logic [1:0] lb);
        byte unsigned     bq [$];
        int               nb;
        int               nblk;
        longint unsigned  bits;
        for (int i = 0; i < n; i++) begin
            nb = (i == n - 1) ? ((lb == 2'd0) ? 4 : int'(lb)) : 4;
            for (int b = 0; b < nb; b++) bq.push_back(msg_words[i][31 - 8 * b -: 8]);
        end
        bits = 64'(bq.size()) * 64'd8;
        bq.push_back(8'h80);
        while (bq.size() % 64 != 56) bq.push_back(8'h00);
        for (int b = 7; b >= 0; b--) bq.push_back(bits[8 * b +: 8]);
        nblk = bq.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            exp_first.push_back(k == 0);
            exp_last.push_back(k == nblk - 1);
            for (int w = 0; w < 16; w++)
                exp_w.push_back({bq[k*64 + w*4], bq[k*64 + w*4 + 1],
                                 bq[k*64 + w*4 + 2], bq[k*64 + w*4 + 3]});
        end
    endtask

    // Per-cycle compare of the schedule side against the expected block queue.
    int        pos = 0;
    int        low_cnt = 0;
    int        done_cnt = 0;
    bit        cur_first = 1'b0;
    bit        cur_last = 1'b0;
    bit        prev_done = 1'b0;
    bit [31:0] ew;

    always @(negedge clk) begin
        if (!reset) begin
            pos = 0;
            low_cnt = 0;
            prev_done = 1'b0;
        end else if (inner_busy) begin
            if (pos == 0) begin
                chk("blk_expected", 64'(exp_first.size() > 0), 1);
                if (exp_first.size() > 0) begin
                    cur_first = exp_first.pop_front();
                    cur_last  = exp_last.pop_front();
                    if (!cur_first) chk("gap_len_ok", 64'(low_cnt >= GAP_CYCLES), 1);
                end
            end
            if (pos < 16) begin
                ew = (exp_w.size() > 0) ? exp_w.pop_front() : 32'hDEAD_BEEF;
                chk("emit_we", write_enable, 1);
                chk("emit_data", data, ew);
            end else begin
                chk("expand_we", write_enable, 0);
                chk("expand_data", data, 0);
            end
            chk("block_first", block_first, 64'(cur_first && pos == 0));
            chk("block_last", block_last, cur_last);
            chk("ready_in_run", msg_ready, 0);
            chk("busy_in_run", busy, 1);
            pos++;
            low_cnt = 0;
            prev_done = 1'b0;
        end else begin
            if (pos != 0) begin
                chk("run_len", pos, 64);
                pos = 0;
                low_cnt = 0;
            end
            chk("idle_we", write_enable, 0);
            chk("idle_block_last", block_last, 0);
            if (msg_done) begin
                chk("done_after_gap", low_cnt, GAP_CYCLES);
                chk("done_last_blk", cur_last, 1);
                chk("done_queue_empty", exp_first.size(), 0);
                chk("done_single_pulse", prev_done, 0);
                chk("done_busy", busy, 0);
                done_cnt++;
            end
            prev_done = msg_done;
            low_cnt++;
        end
    end

    task automatic send_msg(input int n, input logic [1:0] lb, input int stall_pct, input int hold_idx);
        int i = 0;
        int guard = 0;
        int waits = 0;
        bit hs;
        while (i < n && guard < 20000) begin
            if (!msg_valid && $urandom_range(0, 99) >= stall_pct) begin
                msg_valid = 1'b1;
                msg_data  = msg_words[i];
                msg_last  = (i == n - 1);
                msg_bytes = (i == n - 1) ? lb : 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            hs = msg_valid && msg_ready;
            if (msg_valid && !msg_ready) waits++;
            @(posedge clk);
            #1;
            guard++;
            if (hs) begin
                if (i == hold_idx) chk("hold_wait_cycles", waits, 64 + GAP_CYCLES);
                i++;
                waits = 0;
                msg_valid = 1'b0;
                msg_last  = 1'b0;
            end
        end
        chk("send_complete", i, n);
    endtask

    task automatic wait_done(input int start);
        int t = 0;
        while (done_cnt == start && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("msg_done_seen", done_cnt - start, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        msg_words.delete();
        for (int i = 0; i < n; i++) msg_words.push_back($urandom());
    endtask

    task automatic run_msg(input int n, input logic [1:0] lb, input int stall_pct, input int hold_idx);
        int start;
        start = done_cnt;
        send_msg(n, lb, stall_pct, hold_idx);
        wait_done(start);
    endtask

    initial begin
        int t;
        int n;
        reset     = 1'b0;
        msg_valid = 1'b0;
        msg_data  = '0;
        msg_last  = 1'b0;
        msg_bytes = 2'd0;
        #12;
        chk("rst_msg_ready", msg_ready, 0);
        chk("rst_inner_busy", inner_busy, 0);
        chk("rst_write_enable", write_enable, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", {block_first, block_last, msg_done}, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_ready", msg_ready, 1);
        chk("idle_busy", busy, 0);

        // "abc"
        msg_words.delete();
        msg_words.push_back(32'h6162_6300);
        build_expected(1, 2'd3);
        chk("model_abc_w0", exp_w[0], 32'h6162_6380);
        chk("model_abc_w15", exp_w[15], 32'h0000_0018);
        chk("model_abc_nblk", exp_first.size(), 1);
        run_msg(1, 2'd3, 0, -1);

        // 14 full words: length spills into a second block
        fill_random(14);
        build_expected(14, 2'd0);
        chk("model_14w_b1w14", exp_w[14], 32'h8000_0000);
        chk("model_14w_b1w15", exp_w[15], 32'h0);
        chk("model_14w_b2w15", exp_w[31], 32'h0000_01C0);
        chk("model_14w_b1last", exp_last[0], 0);
        run_msg(14, 2'd0, 0, -1);

        // 16 full words: second block is pure padding
        fill_random(16);
        build_expected(16, 2'd0);
        chk("model_16w_b2w0", exp_w[16], 32'h8000_0000);
        chk("model_16w_b2w15", exp_w[31], 32'h0000_0200);
        run_msg(16, 2'd0, 0, -1);

        // 13 words with random stalls, one valid byte in the last
        fill_random(13);
        msg_words[12] = 32'hAABB_CCDD;
        build_expected(13, 2'd1);
        chk("model_13w_w12", exp_w[12], 32'hAA80_0000);
        chk("model_13w_w15", exp_w[15], 32'h0000_0188);
        run_msg(13, 2'd1, 50, -1);

        // valid held through EMIT/EXPAND/GAP: word 16 waits exactly one run plus the gap
        fill_random(20);
        build_expected(20, 2'd2);
        run_msg(20, 2'd2, 0, 16);

        // reset during EXPAND cycle 20
        fill_random(5);
        build_expected(5, 2'd2);
        send_msg(5, 2'd2, 0, -1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!inner_busy && t < 200);
        chk("run_started", inner_busy, 1);
        repeat (36) @(posedge clk);
        #2 reset = 1'b0;
        exp_w.delete();
        exp_first.delete();
        exp_last.delete();
        #1;
        chk("midrst_inner_busy", inner_busy, 0);
        chk("midrst_write_enable", write_enable, 0);
        chk("midrst_data", data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", msg_ready, 0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        msg_words.delete();
        msg_words.push_back(32'h6162_6300);
        build_expected(1, 2'd3);
        run_msg(1, 2'd3, 0, -1);

        // randomized messages
        for (int m = 0; m < 8; m++) begin
            n = $urandom_range(1, 40);
            fill_random(n);
            msg_bytes = 2'($urandom_range(0, 3));
            build_expected(n, msg_bytes);
            run_msg(n, msg_bytes, $urandom_range(0, 40), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
